multicycle_controller: RTL

//  Multi-cycle MIPS control FSM; replaces the single-cycle combinational decoder.

---
 rtl/multicycle_controller.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and strobes, and times out on a stalled memory handshake.
module multicycle_controller #(
  parameter int ALUOP_W     = 4,
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int WAIT_LIMIT  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               readmem,
  output logic               writemem,
  output logic               ir_en,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [ALUOP_W-1:0] aluop,
  output logic [1:0]         pcsrc,
  output logic [3:0]         state,
  output logic               retire,
  output logic               illegal,
  output logic               bus_error
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JUMPR  = 4'd12,
    S_ERR    = 4'd15
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [3:0] alu_c;
  logic       ready_eff;
  logic       timeout;
  logic       mem_state;

  function automatic logic r_func_ok(input logic [5:0] f);
    return f inside {6'd0, 6'd2, 6'd3, 6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd39, 6'd42};
  endfunction

  function automatic logic [3:0] r_aluop(input logic [5:0] f);
    case (f)
      6'd32, 6'd33: return 4'h8;
      6'd34, 6'd35: return 4'hA;
      6'd36:        return 4'hC;
      6'd37:        return 4'hD;
      6'd39:        return 4'hF;
      6'd42:        return 4'h5;
      6'd2:         return 4'h2;
      6'd3:         return 4'h3;
      default:      return 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] i_aluop(input logic [5:0] op);
    case (op)
      6'h0A:   return 4'h5;
      6'h0C:   return 4'hC;
      6'h0D:   return 4'hD;
      default: return 4'h8;
    endcase
  endfunction

  // With waiting disabled every memory access completes in its first cycle.
  assign ready_eff = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign timeout   = MEM_WAIT_EN && !mem_ready && (wait_q == 8'(WAIT_LIMIT));
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of its peers.
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    state_d   = S_FETCH;
    pc_en     = 1'b0;
    iord      = 1'b0;
    readmem   = 1'b0;
    writemem  = 1'b0;
    ir_en     = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'd0;
    alu_c     = 4'h0;
    pcsrc     = 2'd0;
    retire    = 1'b0;
    illegal   = 1'b0;
    bus_error = 1'b0;

    case (state_q)
      S_FETCH: begin
        readmem = 1'b1;
        alusrcb = 2'd1;
        alu_c   = 4'h8;
        if (ready_eff) begin
          ir_en   = 1'b1;
          pc_en   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_ERR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        alusrcb = 2'd3;
        alu_c   = 4'h8;
        case (opcode)
          6'h00: begin
            if (func == 6'd8)        state_d = S_JUMPR;
            else if (r_func_ok(func)) state_d = S_EXEC;
            else                      illegal = 1'b1;
          end
          6'h23, 6'h2B:               state_d = S_MEMADR;
          6'h04:                      state_d = S_BRANCH;
          6'h02:                      state_d = S_JUMP;
          6'h08, 6'h0A, 6'h0C, 6'h0D: state_d = S_IEXEC;
          default:                    illegal = 1'b1;
        endcase
      end
      S_EXEC: begin
        alusrca = 1'b1;
        alu_c   = r_aluop(func);
        state_d = S_RWB;
      end
      S_RWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'd2;
        alu_c   = i_aluop(opcode);
        state_d = S_IWB;
      end
      S_IWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'd2;
        alu_c   = 4'h8;
        state_d = (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        readmem = 1'b1;
        if (ready_eff)    state_d = S_MEMWB;
        else if (timeout) state_d = S_ERR;
        else              state_d = S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        writemem = 1'b1;
        if (ready_eff) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_ERR;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        alu_c   = 4'hA;
        pcsrc   = 2'd1;
        pc_en   = zero;
        retire  = 1'b1;
      end
      S_JUMP: begin
        pcsrc  = 2'd2;
        pc_en  = 1'b1;
        retire = 1'b1;
      end
      S_JUMPR: begin
        pcsrc  = 2'd3;
        pc_en  = 1'b1;
        retire = 1'b1;
      end
      S_ERR: begin
        bus_error = 1'b1;
        state_d   = S_ERR;
      end
      default: state_d = S_FETCH;
    endcase

    // Every memory state exits on ready or timeout, so "still here" means a wait cycle.
    wait_d = (mem_state && (state_d == state_q)) ? wait_q + 8'd1 : 8'd0;

    aluop = ALUOP_W'(alu_c);
    state = state_q;

    // Reset overrides combinationally so no strobe survives into the reset cycle.
    if (rst) begin
      {pc_en, iord, readmem, writemem, ir_en, regdst, memtoreg, regwrite, alusrca,
       alusrcb, pcsrc, retire, illegal, bus_error} = '0;
      aluop = '0;
      state = '0;
    end
  end

endmodule
